// File: rtl/mux4_frame_sequencer_pkg.sv
// ============================================================================
//  Module      : mux4_seq_pkg
//  Description : Shared constants, FSM state encoding and parity helper for
//                the 4:1 mux frame sequencer.
//  Optional    : MUX4_SEQ_PARITY_EN (parity helper only used when defined)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux4_seq_pkg;

   localparam int WIDTH    = 4;   // data word width, matches the 4:1 mux
   localparam int ADDR_W   = 2;   // select width, clog2(WIDTH)
   localparam int LAST_IDX = 3;   // select value of the final data beat

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   // Parity bit appended to a frame: even sense when odd_i=0, odd sense when 1.
   function automatic logic frame_parity(input logic [WIDTH-1:0] word_i,
                                         input logic             odd_i);
      return (^word_i) ^ odd_i;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_frame_sequencer_if.sv
// ============================================================================
//  Module      : mux4_frame_sequencer_if
//  Description : Word-in / mux-out bundle of the frame sequencer.
//                master : word producer + mux consumer side (drives in_*)
//                slave  : sequencer side (drives in_ready and mux/ser outputs)
//  Ports       : in_data, in_valid, in_ready  - word handshake
//                mux_d, mux_a                 - 4:1 mux data and select
//                ser_valid, ser_last          - serial bit qualifiers
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux4_frame_sequencer_if;
   import mux4_seq_pkg::*;

   logic [WIDTH-1:0]  in_data;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  mux_d;
   logic [ADDR_W-1:0] mux_a;
   logic              ser_valid;
   logic              ser_last;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mux_d,
      input  mux_a,
      input  ser_valid,
      input  ser_last
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mux_d,
      output mux_a,
      output ser_valid,
      output ser_last
   );

endinterface

`default_nettype wire

// File: rtl/mux4_frame_sequencer_bitcnt.sv
// ============================================================================
//  Module      : mux4_seq_bitcnt
//  Description : Mux select counter. Clear has priority over enable; tc_o
//                flags the last data beat (count == LAST_IDX).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                clr_i           - force count to zero
//                en_i            - advance count by one
//                cnt_o           - current select value
//                tc_o            - terminal count
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux4_seq_bitcnt
   import mux4_seq_pkg::*;
(
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              clr_i,
   input  wire logic              en_i,
   output      logic [ADDR_W-1:0] cnt_o,
   output      logic              tc_o
);

   logic [ADDR_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == ADDR_W'(LAST_IDX));

endmodule

`default_nettype wire

// File: rtl/mux4_frame_sequencer.sv
// ============================================================================
//  Module      : mux4_frame_sequencer
//  Description : Upstream sequencer for a 4:1 data mux. Holds each accepted
//                word on mux_d and steps mux_a 0..3 so the mux output is a
//                serial bitstream, LSB first, qualified by ser_valid/ser_last.
//  Parameters  : WIDTH (4 only), ADDR_W (2 only), PAR_ODD (parity sense)
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                bus       - mux4_frame_sequencer_if.slave
//  Optional    : MUX4_SEQ_PARITY_EN adds a 5th parity beat per frame
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux4_frame_sequencer #(
   parameter int WIDTH   = mux4_seq_pkg::WIDTH,
   parameter int ADDR_W  = mux4_seq_pkg::ADDR_W,
   parameter int PAR_ODD = 0
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   mux4_frame_sequencer_if.slave         bus
);
   import mux4_seq_pkg::*;

   // Elaboration-time guards on the fixed geometry and parity sense.
   if (WIDTH != 4 || ADDR_W != 2) begin : g_bad_geometry
      $error("mux4_frame_sequencer supports only WIDTH=4, ADDR_W=2");
   end
   if (PAR_ODD != 0 && PAR_ODD != 1) begin : g_bad_par_odd
      $error("mux4_frame_sequencer PAR_ODD must be 0 or 1");
   end

   state_t             state_q;
   logic [WIDTH-1:0]   mux_d_q;
   logic               ser_valid_q;
   logic               ser_last_q;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_cnt_clr;
   logic               w_cnt_en;
   logic [ADDR_W-1:0]  w_cnt;
   logic               w_tc;

   // Ready depends on registers only, so a new word can land exactly on
   // the last beat of the current frame with no bubble.
   assign w_in_ready = (state_q == IDLE) || ser_last_q;
   assign w_accept   = bus.in_valid && w_in_ready;

   // Select restarts at 0 outside SHIFT and at every frame boundary, so it
   // never wraps inside a frame.
   assign w_cnt_clr  = (state_q != SHIFT) || w_tc;
   assign w_cnt_en   = (state_q == SHIFT) && !w_tc;

   mux4_seq_bitcnt u_bitcnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (w_cnt_clr),
      .en_i  (w_cnt_en),
      .cnt_o (w_cnt),
      .tc_o  (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mux_d_q     <= '0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_accept) begin
                  state_q     <= SHIFT;
                  mux_d_q     <= bus.in_data;
                  ser_valid_q <= 1'b1;
                  ser_last_q  <= 1'b0;
               end
            end

            SHIFT: begin
`ifdef MUX4_SEQ_PARITY_EN
               if (w_tc) begin
                  // Replicating p on every mux input makes the output p
                  // regardless of select.
                  state_q    <= PAR;
                  mux_d_q    <= {WIDTH{frame_parity(mux_d_q, 1'(PAR_ODD))}};
                  ser_last_q <= 1'b1;
               end else begin
                  ser_last_q <= 1'b0;
               end
`else
               if (w_tc) begin
                  if (w_accept) begin
                     mux_d_q     <= bus.in_data;
                     ser_valid_q <= 1'b1;
                     ser_last_q  <= 1'b0;
                  end else begin
                     state_q     <= IDLE;
                     mux_d_q     <= '0;
                     ser_valid_q <= 1'b0;
                     ser_last_q  <= 1'b0;
                  end
               end else begin
                  // Flag the beat on which the select reaches LAST_IDX.
                  ser_last_q <= (w_cnt == ADDR_W'(LAST_IDX - 1));
               end
`endif
            end

`ifdef MUX4_SEQ_PARITY_EN
            PAR: begin
               if (w_accept) begin
                  state_q     <= SHIFT;
                  mux_d_q     <= bus.in_data;
                  ser_valid_q <= 1'b1;
                  ser_last_q  <= 1'b0;
               end else begin
                  state_q     <= IDLE;
                  mux_d_q     <= '0;
                  ser_valid_q <= 1'b0;
                  ser_last_q  <= 1'b0;
               end
            end
`endif

            default: begin
               state_q     <= IDLE;
               mux_d_q     <= '0;
               ser_valid_q <= 1'b0;
               ser_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.mux_d     = mux_d_q;
   assign bus.mux_a     = w_cnt;
   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_last  = ser_last_q;

endmodule

`default_nettype wire

// File: tb/tb_mux4_frame_sequencer.sv
// ============================================================================
//  Module      : tb_mux4_frame_sequencer
//  Description : Self-checking bench for mux4_frame_sequencer driving a
//                behavioural 4:1 mux (Y = mux_d[mux_a]). Expected beats are
//                queued on every accepted word and popped by a monitor.
//  Optional    : MUX4_SEQ_PARITY_EN (adds a PAR_ODD=1 instance)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux4_frame_sequencer;

`ifdef MUX4_SEQ_PARITY_EN
   localparam bit TB_PAR = 1'b1;
`else
   localparam bit TB_PAR = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] word;   // word to send
      logic [3:0] seq;    // expected Y, first beat in bit 3
      logic       par;    // expected even-parity bit
   } vec_t;

   typedef struct packed {
      logic [1:0] a;
      logic [3:0] d;
      logic       y;
      logic       last;
      logic       is_par;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mon_en = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   beat_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mux4_frame_sequencer_if bus ();

   mux4_frame_sequencer #(.WIDTH(4), .ADDR_W(2), .PAR_ODD(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef MUX4_SEQ_PARITY_EN
   mux4_frame_sequencer_if bus_odd ();
   assign bus_odd.in_data  = bus.in_data;
   assign bus_odd.in_valid = bus.in_valid;

   mux4_frame_sequencer #(.WIDTH(4), .ADDR_W(2), .PAR_ODD(1)) dut_odd (
      .clk (clk),
      .rst (rst),
      .bus (bus_odd)
   );
`endif

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input vec_t v);
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{a: 2'(i), d: v.word, y: v.seq[3 - i],
                        last: (i == 3) && !TB_PAR, is_par: 1'b0});
      end
      if (TB_PAR) begin
         sb.push_back('{a: 2'd0, d: {4{v.par}}, y: v.par, last: 1'b1, is_par: 1'b1});
      end
   endtask

   // Called right after a negedge; returns right after the next negedge
   // following the accepting edge, with in_valid still high.
   task automatic send(input vec_t v, output int acc_cyc);
      int n;
      n = 0;
      acc_cyc = -1;
      bus.in_data  = v.word;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         chk("accept_timeout", 8'd0, 8'd1);
      end else begin
         acc_cyc = cyc;
         @(posedge clk);
         push_word(v);
      end
      @(negedge clk);
   endtask

   // Monitor: behavioural 4:1 mux plus scoreboard compare.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [3:0] d;
         logic [1:0] a;
         logic       y;
         beat_t      e;
         d = bus.mux_d;
         a = bus.mux_a;
         y = d[a];
         if (bus.ser_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", 8'd1, 8'd0);
            end else begin
               e = sb.pop_front();
               chk("mux_a",    8'(a),             8'(e.a));
               chk("mux_d",    8'(d),             8'(e.d));
               chk("Y",        8'(y),             8'(e.y));
               chk("ser_last", 8'(bus.ser_last),  8'(e.last));
               chk("in_ready", 8'(bus.in_ready),  8'(e.last));
`ifdef MUX4_SEQ_PARITY_EN
               chk("odd_Y", 8'(bus_odd.mux_d[bus_odd.mux_a]), 8'(e.is_par ? ~e.y : e.y));
               if (e.is_par) begin
                  chk("odd_par_d", 8'(bus_odd.mux_d), 8'({4{~e.y}}));
               end
`endif
            end
         end else begin
            chk("idle_outputs", {2'b00, bus.ser_last, bus.in_ready, bus.mux_a, 2'b00},
                                8'b0001_0000);
            chk("idle_mux_d", 8'(d), 8'h00);
         end
      end
   end

   initial begin
      vec_t tbl [6];
      vec_t v;
      int   acc [6];
      int   a0;

      tbl[0] = '{word: 4'hA, seq: 4'b0101, par: 1'b0};
      tbl[1] = '{word: 4'h5, seq: 4'b1010, par: 1'b0};
      tbl[2] = '{word: 4'h8, seq: 4'b0001, par: 1'b1};
      tbl[3] = '{word: 4'h6, seq: 4'b0110, par: 1'b0};
      tbl[4] = '{word: 4'h1, seq: 4'b1000, par: 1'b1};
      tbl[5] = '{word: 4'hE, seq: 4'b0111, par: 1'b1};

      // Reset held two cycles with in_valid asserted.
      bus.in_data  = 4'hF;
      bus.in_valid = 1'b1;
      rst          = 1'b1;
      @(posedge clk);
      mon_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      chk("ready_after_reset", 8'(bus.in_ready), 8'd1);
      @(negedge clk);

      // Single word 1011, then idle.
      v = '{word: 4'b1011, seq: 4'b1101, par: 1'b1};
      send(v, a0);
      bus.in_valid = 1'b0;
      repeat (7) @(negedge clk);

      // Back-to-back table with in_valid held: spacing must be one frame.
      for (int i = 0; i < 6; i++) begin
         send(tbl[i], acc[i]);
         if (i > 0) begin
            chk("b2b_spacing", 8'(acc[i] - acc[i-1]), TB_PAR ? 8'd5 : 8'd4);
         end
      end
      bus.in_valid = 1'b0;
      repeat (7) @(negedge clk);

      // in_data changes and in_valid toggles while not ready: ignored.
      v = '{word: 4'h6, seq: 4'b0110, par: 1'b0};
      send(v, a0);
      for (int j = 0; j < 3; j++) begin
         bus.in_valid = (j % 2) == 1;
         bus.in_data  = 4'($urandom_range(0, 15));
         chk("busy_not_ready", 8'(bus.in_ready), 8'd0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      repeat (7) @(negedge clk);

      // Reset mid-frame after bit1 of 4'hF; the rest of the frame is dropped.
      v = '{word: 4'hF, seq: 4'b1111, par: 1'b0};
      send(v, a0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("ready_after_abort", 8'(bus.in_ready), 8'd1);
      v = '{word: 4'h3, seq: 4'b1100, par: 1'b0};
      send(v, a0);
      bus.in_valid = 1'b0;
      repeat (8) @(negedge clk);

      chk("scoreboard_drained", 8'(sb.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
